// File: rtl/hand_gesture_decider_if.sv
// Row-in / result-out bundle for the hand gesture decider.
// The slave modport is the decider; the master is the mask source and result consumer.
interface hand_gesture_decider_if #(parameter int WIDTH = 8);
    logic             row_valid;
    logic             row_ready;
    logic [WIDTH-1:0] row_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       gesture;
    logic [31:0]      sum;
    logic [31:0]      sum_left;
    logic [7:0]       leftmost;
    logic [7:0]       fingers;

    modport master (
        output row_valid, row_data, out_ready,
        input  row_ready, out_valid, gesture, sum, sum_left, leftmost, fingers
    );
    modport slave (
        input  row_valid, row_data, out_ready,
        output row_ready, out_valid, gesture, sum, sum_left, leftmost, fingers
    );
endinterface

// File: rtl/hand_gesture_decider.sv
// Buffers one binary hand mask frame, accumulates pixel statistics, scans a vertical
// strip for finger crossings and reports a rock/paper/scissors decision.
module hand_gesture_decider #(
    parameter int LENGTH       = 8,
    parameter int WIDTH        = 8,
    parameter int LEFT         = 4,
    parameter int STRIP_OFFSET = 2,
    parameter int MIN_PIXELS   = 4
) (
    input logic clk,
    input logic rst,
    hand_gesture_decider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

    localparam int AW    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] G_ROCK     = 2'b00;
    localparam logic [1:0] G_PAPER    = 2'b01;
    localparam logic [1:0] G_SCISSORS = 2'b10;
    localparam logic [1:0] G_NONE     = 2'b11;

    function automatic logic [31:0] popcount(input logic [WIDTH-1:0] r, input int n);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < n; i++) c = c + {31'b0, r[i]};
        return c;
    endfunction

    function automatic logic [7:0] lowest(input logic [WIDTH-1:0] r);
        logic [7:0] idx;
        idx = 8'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) if (r[i]) idx = 8'(i);
        return idx;
    endfunction

    function automatic logic [1:0] classify(input logic [7:0] f);
        if (f <= 8'd1)      return G_ROCK;
        else if (f <= 8'd3) return G_SCISSORS;
        else                return G_PAPER;
    endfunction

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    row_cnt, scan_idx;
    logic [31:0]      acc_sum, acc_left;
    logic [7:0]       acc_lm, fcnt;
    logic             prev_bit;
    logic [CW-1:0]    strip_col;

    logic             row_fire, last_row, scan_bit, scan_last;
    logic [31:0]      new_sum, new_left;
    logic [7:0]       row_lm, new_lm, new_f;
    logic [8:0]       lm_off;
    logic [CW-1:0]    clamp_col;

    assign row_fire  = bus.row_valid && bus.row_ready;
    assign last_row  = (row_cnt == AW'(LENGTH - 1));
    assign scan_last = (scan_idx == AW'(LENGTH - 1));
    assign new_sum   = acc_sum + popcount(bus.row_data, WIDTH);
    assign new_left  = acc_left + popcount(bus.row_data, LEFT);
    assign row_lm    = lowest(bus.row_data);
    assign new_lm    = (row_lm < acc_lm) ? row_lm : acc_lm;
    // Widened to 9 bits so leftmost=WIDTH plus the offset can never wrap past the clamp.
    assign lm_off    = {1'b0, new_lm} + 9'(STRIP_OFFSET);
    assign clamp_col = (lm_off > 9'(WIDTH - 1)) ? CW'(WIDTH - 1) : lm_off[CW-1:0];
    assign scan_bit  = mem[scan_idx][strip_col];
    assign new_f     = (scan_bit && !prev_bit && fcnt != 8'hFF) ? fcnt + 8'd1 : fcnt;

    always_ff @(posedge clk) begin
        if (row_fire) mem[row_cnt] <= bus.row_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.row_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.gesture   <= G_NONE;
            bus.sum       <= '0;
            bus.sum_left  <= '0;
            bus.leftmost  <= 8'(WIDTH);
            bus.fingers   <= '0;
            acc_sum       <= '0;
            acc_left      <= '0;
            acc_lm        <= 8'(WIDTH);
            fcnt          <= '0;
            prev_bit      <= 1'b0;
            row_cnt       <= '0;
            scan_idx      <= '0;
            strip_col     <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (row_fire) begin
                        acc_sum  <= new_sum;
                        acc_left <= new_left;
                        acc_lm   <= new_lm;
                        row_cnt  <= row_cnt + AW'(1);
                        state    <= ACCUM;
                        if (last_row) begin
                            row_cnt       <= '0;
                            bus.row_ready <= 1'b0;
                            if (new_sum < 32'(MIN_PIXELS)) begin
                                state         <= DONE;
                                bus.out_valid <= 1'b1;
                                bus.gesture   <= G_NONE;
                                bus.sum       <= new_sum;
                                bus.sum_left  <= new_left;
                                bus.leftmost  <= new_lm;
                                bus.fingers   <= '0;
                            end else begin
                                state     <= SCAN;
                                strip_col <= clamp_col;
                                scan_idx  <= '0;
                                fcnt      <= '0;
                                prev_bit  <= 1'b0;
                            end
                        end
                    end
                end
                SCAN: begin
                    prev_bit <= scan_bit;
                    fcnt     <= new_f;
                    scan_idx <= scan_idx + AW'(1);
                    if (scan_last) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.gesture   <= classify(new_f);
                        bus.sum       <= acc_sum;
                        bus.sum_left  <= acc_left;
                        bus.leftmost  <= acc_lm;
                        bus.fingers   <= new_f;
                    end
                end
                DONE: begin
                    // Result registers hold until the next DONE entry; only the accumulators clear.
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.row_ready <= 1'b1;
                        acc_sum       <= '0;
                        acc_left      <= '0;
                        acc_lm        <= 8'(WIDTH);
                        fcnt          <= '0;
                        row_cnt       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hand_gesture_decider.sv
// Directed vector table plus backpressure and reset-abort sequences for hand_gesture_decider.
module tb_hand_gesture_decider;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    hand_gesture_decider_if #(.WIDTH(8)) bus ();

    hand_gesture_decider #(
        .LENGTH(8), .WIDTH(8), .LEFT(4), .STRIP_OFFSET(2), .MIN_PIXELS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [7:0][7:0] rows;   // row 0 is the most significant byte
        logic [1:0]      g;
        int              s, sl, lm, f, lat;
    } vec_t;

    vec_t vt[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " out_valid"}, {31'b0, bus.out_valid}, 0);
        check({tag, " row_ready"}, {31'b0, bus.row_ready}, 1);
        check({tag, " gesture"},   {30'b0, bus.gesture}, 3);
        check({tag, " sum"},       bus.sum, 0);
        check({tag, " sum_left"},  bus.sum_left, 0);
        check({tag, " leftmost"},  {24'b0, bus.leftmost}, 8);
        check({tag, " fingers"},   {24'b0, bus.fingers}, 0);
    endtask

    task automatic send_rows(input logic [7:0][7:0] rows, input bit gaps, input int n);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                bus.row_valid = 1'b0;
                step();
            end
            bus.row_valid = 1'b1;
            bus.row_data  = rows[7-i];
            step();
        end
        bus.row_valid = 1'b0;
        bus.row_data  = '0;
    endtask

    task automatic wait_result(input string name, input int exp_lat);
        int n;
        n = 1;
        while (!bus.out_valid && n < 50) begin
            step();
            n++;
        end
        check({name, " latency"}, n, exp_lat);
    endtask

    task automatic check_result(input vec_t v);
        check({v.name, " out_valid"}, {31'b0, bus.out_valid}, 1);
        check({v.name, " row_ready"}, {31'b0, bus.row_ready}, 0);
        check({v.name, " gesture"},   {30'b0, bus.gesture}, {30'b0, v.g});
        check({v.name, " sum"},       bus.sum, v.s);
        check({v.name, " sum_left"},  bus.sum_left, v.sl);
        check({v.name, " leftmost"},  {24'b0, bus.leftmost}, v.lm);
        check({v.name, " fingers"},   {24'b0, bus.fingers}, v.f);
    endtask

    task automatic release_result(input string name);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({name, " release out_valid"}, {31'b0, bus.out_valid}, 0);
        check({name, " release row_ready"}, {31'b0, bus.row_ready}, 1);
    endtask

    task automatic run_frame(input vec_t v, input bit gaps);
        send_rows(v.rows, gaps, 8);
        wait_result(v.name, v.lat);
        check_result(v);
        release_result(v.name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{"zeros",    64'h0000000000000000, 2'd3,  0,  0, 8, 0, 1};
        vt[1] = '{"ones",     64'hFFFFFFFFFFFFFFFF, 2'd0, 64, 32, 0, 1, 9};
        vt[2] = '{"paper",    64'h0F000F000F000F00, 2'd1, 16, 16, 0, 4, 9};
        vt[3] = '{"scissors", 64'h3C003C0000000000, 2'd2,  8,  4, 2, 2, 9};
        vt[4] = '{"clamp",    64'h8080808080808080, 2'd0,  8,  0, 7, 1, 9};
        vt[5] = '{"below_min",64'h0101010000000000, 2'd3,  3,  3, 0, 0, 1};
        vt[6] = '{"at_min",   64'h0100010001000100, 2'd0,  4,  4, 0, 0, 9};
        vt[7] = '{"three",    64'h0500050005000000, 2'd2,  6,  6, 0, 3, 9};

        rst           = 1'b1;
        bus.row_valid = 1'b0;
        bus.row_data  = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset_vals("reset");

        // out_ready while idle must not disturb anything
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_reset_vals("early_ready");

        for (int k = 0; k < 8; k++) run_frame(vt[k], 1'b0);

        begin
            vec_t g;
            g = vt[2];
            g.name = "gapped";
            run_frame(g, 1'b1);
        end

        // Backpressure: result held, extra rows ignored
        send_rows(vt[2].rows, 1'b0, 8);
        wait_result("bp", 9);
        bus.row_valid = 1'b1;
        bus.row_data  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp hold out_valid", {31'b0, bus.out_valid}, 1);
            check("bp hold row_ready", {31'b0, bus.row_ready}, 0);
            check("bp hold sum", bus.sum, 16);
            check("bp hold gesture", {30'b0, bus.gesture}, 1);
            check("bp hold fingers", {24'b0, bus.fingers}, 4);
        end
        bus.row_valid = 1'b0;
        bus.row_data  = '0;
        release_result("bp");
        run_frame(vt[3], 1'b0);

        // Reset in the middle of a frame
        begin
            vec_t a;
            a = '{"after_rst", 64'h0F000F000F000F00, 2'd1, 16, 16, 0, 4, 9};
            send_rows(64'hFFFFFFFFFFFFFFFF, 1'b0, 3);
            rst = 1'b1;
            step();
            rst = 1'b0;
            check_reset_vals("abort");
            run_frame(a, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hand_gesture_decider.md
# hand_gesture_decider

Downstream stage of the green-filter classifier. It accepts the binary hand mask one row per cycle over a valid/ready handshake and buffers the whole frame. It accumulates the total and left-region pixel counts and the leftmost hand column. A second pass counts finger crossings along a vertical strip, and the block then outputs a rock/paper/scissors decision with its statistics.

## Interface
- LENGTH, 8: mask rows per frame (1..255)
- WIDTH, 8: mask columns per row (1..255); column j is bit j, column 0 is the left edge
- LEFT, 4: columns 0..LEFT-1 form the left region
- STRIP_OFFSET, 2: strip column = leftmost + STRIP_OFFSET, clamped to WIDTH-1
- MIN_PIXELS, 4: a frame with sum < MIN_PIXELS is reported as NONE
- clk  input  1  system clock, all state on posedge
- rst  input  1  reset; synchronous and active-high
- row_valid  input  1  row_data is valid this cycle
- row_ready  output  1  block can accept a row
- row_data  input  WIDTH  one mask row, top row first
- out_valid  output  1  result is valid and held
- out_ready  input  1  consumer accepts the result
- gesture  output  2  00 ROCK, 01 PAPER, 10 SCISSORS, 11 NONE
- sum  output  32  set pixels in the frame
- sum_left  output  32  set pixels in columns < LEFT
- leftmost  output  8  smallest column index holding a set pixel; WIDTH if there is none
- fingers  output  8  0->1 transitions down the strip column, saturating at 255

## Operation
- States: IDLE, ACCUM, SCAN, DONE.
- IDLE/ACCUM:
  - row_ready=1.
  - Each accepted row is written to a LENGTH x WIDTH row buffer at index row_cnt.
  - sum += popcount(row); sum_left += popcount(row[LEFT-1:0]).
  - leftmost = min(leftmost, lowest set bit index of row). An all-zero row leaves leftmost unchanged.
  - Leave IDLE on the first accepted row.
- Last row (row_cnt = LENGTH-1) accepted:
  - If final sum < MIN_PIXELS: go to DONE with gesture=NONE and fingers=0.
  - Otherwise go to SCAN.
- SCAN:
  - row_ready=0.
  - Strip column c = min(leftmost+STRIP_OFFSET, WIDTH-1).
  - Read buffer rows 0..LENGTH-1, one per cycle.
  - Increment fingers whenever bit c of the row is 1 and the previous row's bit c was 0. The "previous" bit before row 0 is 0.
- End of SCAN, classification:
  - fingers <= 1: ROCK.
  - fingers 2..3: SCISSORS.
  - fingers >= 4: PAPER.
- DONE:
  - out_valid=1, row_ready=0.
  - All result outputs are registered and stable until out_valid && out_ready.
  - On that handshake: go to IDLE and clear the accumulators (sum=0, sum_left=0, leftmost=WIDTH, fingers=0, row_cnt=0).
- Result outputs change only when DONE is entered or on reset.
- Arithmetic:
  - sum and sum_left are 32-bit unsigned with no overflow possible within the parameter range.
  - The leftmost+STRIP_OFFSET comparison is done at 9 bits, so the clamp cannot wrap.

## Timing
- Reset (rst high at a clock edge) forces, from the next cycle:
  - state IDLE, row_ready=1, out_valid=0
  - gesture=11, sum=0, sum_left=0, leftmost=WIDTH, fingers=0
  - row_cnt and row buffer contents discarded
- Reset applies in any state. It aborts a partial frame, SCAN, or a pending result.
- Throughput: one row per cycle while row_ready=1. row_valid with row_ready=0 is ignored; rows are not queued.
- Latency, with the last row accepted at edge T:
  - Normal frame: SCAN occupies cycles T+1..T+LENGTH; out_valid rises at T+LENGTH+1.
  - NONE frame: out_valid rises at T+1.
- out_ready high on the first out_valid cycle releases the result after 1 cycle. row_ready returns in the following cycle (IDLE).
- out_ready before out_valid has no effect.
- A frame's rows may be non-contiguous (row_valid gaps); only accepted rows count.

## Test plan
Parameters for all cases: LENGTH=8, WIDTH=8, LEFT=4, STRIP_OFFSET=2, MIN_PIXELS=4.
- Eight rows 8'h00 -> out_valid 1 cycle after the last row; gesture=11, sum=0, sum_left=0, leftmost=8, fingers=0.
- Eight rows 8'hFF -> out_valid 9 cycles after the last row; sum=64, sum_left=32, leftmost=0, fingers=1, gesture=ROCK.
- Rows 0F,00,0F,00,0F,00,0F,00 -> sum=16, sum_left=16, leftmost=0, strip column 2, fingers=4, gesture=PAPER.
- Rows 3C,00,3C,00,00,00,00,00 -> sum=8, sum_left=4, leftmost=2, strip column 4, fingers=2, gesture=SCISSORS.
- Backpressure: frame from the third case with out_ready=0 held for 10 cycles while row_valid=1 -> all outputs constant and row_ready=0 throughout. Raise out_ready -> out_valid falls next cycle; the following frame is accepted and reports only its own rows.
- rst pulsed after 3 accepted rows of 8'hFF, then a full 8'h0F/00 frame -> all outputs equal reset values immediately after rst. Result: sum=16, leftmost=0, gesture=PAPER, with no carry-over from the aborted rows.
